// File: rtl/mem_writeback_unit.sv
// Writeback stage: retires ALU results directly, runs one load/store at a time
// against data memory, and owns the register file with bypassed read ports.
module mem_writeback_unit #(
   parameter  int XLEN    = 32,
   parameter  int NREGS   = 16,
   parameter  int AW      = 10,
   parameter  int TIMEOUT = 15,
   localparam int RW      = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_kind,
   input  logic [RW-1:0]   in_rd,
   input  logic [XLEN-1:0] in_result,
   input  logic [AW-1:0]   in_addr,
   input  logic [XLEN-1:0] in_sdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic [RW-1:0]   ra0,
   input  logic [RW-1:0]   ra1,
   output logic [XLEN-1:0] rd0,
   output logic [XLEN-1:0] rd1,
   input  logic [RW-1:0]   dbg_sel,
   output logic [XLEN-1:0] dbg_data,
   output logic            err,
   input  logic            err_clr,
   output logic [15:0]     retired
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state;
   logic [XLEN-1:0] regs [NREGS];
   logic [RW-1:0]   lat_rd;
   logic            lat_store;
   logic [7:0]      tcnt;

   logic            accept, alu_wr, mem_op, ack_busy, timeout;
   logic            wr_en, commit;
   logic [RW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;

   // Handshake: an operation transfers on a cycle where in_valid and in_ready are both high.
   assign in_ready = (state == IDLE);
   assign accept   = in_valid & in_ready;
   assign alu_wr   = accept & (in_kind == 2'b00);
   assign mem_op   = accept & (in_kind == 2'b01 || in_kind == 2'b10);
   assign ack_busy = (state == BUSY) & mem_ack;
   assign timeout  = (state == BUSY) & ~mem_ack & (tcnt == 8'(TIMEOUT - 1));

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (alu_wr) begin
         wr_en   = 1'b1;
         wr_addr = in_rd;
         wr_data = in_result;
      end else if (ack_busy && !lat_store) begin
         wr_en   = 1'b1;
         wr_addr = lat_rd;
         wr_data = mem_rdata;
      end
   end

   // Register 0 is hardwired; writes to it still retire but never land.
   assign commit = wr_en & (wr_addr != '0);

   assign rd0 = (ra0 == '0) ? '0 : (commit && wr_addr == ra0) ? wr_data : regs[ra0];
   assign rd1 = (ra1 == '0) ? '0 : (commit && wr_addr == ra1) ? wr_data : regs[ra1];
   assign dbg_data = (dbg_sel == '0) ? '0 : regs[dbg_sel];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lat_rd    <= '0;
         lat_store <= 1'b0;
         tcnt      <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         err       <= 1'b0;
         retired   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_op) begin
                  state     <= BUSY;
                  lat_rd    <= in_rd;
                  lat_store <= in_kind[1];
                  tcnt      <= '0;
                  mem_req   <= 1'b1;
                  mem_we    <= in_kind[1];
                  mem_addr  <= in_addr;
                  mem_wdata <= in_sdata;
               end
            end
            BUSY: begin
               if (mem_ack || timeout) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
         // A timeout in the same cycle as err_clr wins.
         if (timeout)      err <= 1'b1;
         else if (err_clr) err <= 1'b0;
         if (alu_wr || ack_busy) retired <= retired + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (commit) begin
         regs[wr_addr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_mem_writeback_unit.sv
// Directed bench for mem_writeback_unit: inputs driven 1ns after the rising edge,
// outputs compared 2ns after it, expected values written out by hand.
module tb_mem_writeback_unit;

   localparam int XLEN = 32;
   localparam int RW   = 4;
   localparam int AW   = 10;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      in_kind;
   logic [RW-1:0]   in_rd;
   logic [XLEN-1:0] in_result;
   logic [AW-1:0]   in_addr;
   logic [XLEN-1:0] in_sdata;
   logic            mem_req, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic            mem_ack;
   logic [XLEN-1:0] mem_rdata;
   logic [RW-1:0]   ra0, ra1, dbg_sel;
   logic [XLEN-1:0] rd0, rd1, dbg_data;
   logic            err, err_clr;
   logic [15:0]     retired;

   int n_checks = 0;
   int n_pass   = 0;
   int req_cycles;

   mem_writeback_unit dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_rd(in_rd),
      .in_result(in_result), .in_addr(in_addr), .in_sdata(in_sdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data),
      .err(err), .err_clr(err_clr), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [1:0] kind, input logic [RW-1:0] rd,
                           input logic [31:0] result, input logic [AW-1:0] addr,
                           input logic [31:0] sdata);
      in_valid  = 1'b1;
      in_kind   = kind;
      in_rd     = rd;
      in_result = result;
      in_addr   = addr;
      in_sdata  = sdata;
   endtask

   // Issue a store, then count cycles with mem_req high (bounded); optionally
   // pulse err_clr in the final busy cycle. Returns at +2ns of the first idle cycle.
   task automatic run_store(input logic [AW-1:0] addr, input logic [31:0] data,
                            input bit clr_last, output int cycles);
      drive_op(2'b10, 4'd0, 32'h0, addr, data);
      next_cycle();
      in_valid = 1'b0;
      cycles = 0;
      while (cycles < 40) begin
         #1;
         if (!mem_req) break;
         cycles++;
         if (cycles == 1) begin
            check("store_we", {31'b0, mem_we}, 32'd1);
            check("store_addr", {22'b0, mem_addr}, 32'h3FF);
            check("store_wdata", mem_wdata, 32'hA5A5A5A5);
         end
         if (clr_last && cycles == 15) err_clr = 1'b1;
         @(posedge clk);
         #1;
         err_clr = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_kind = 2'b11; in_rd = '0; in_result = '0;
      in_addr = '0; in_sdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      ra0 = '0; ra1 = '0; dbg_sel = '0; err_clr = 1'b0;

      // Reset values, observed while reset is held
      #12;
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_retired", {16'b0, retired}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU write r3 with same-cycle bypass; debug port must not bypass
      next_cycle();
      drive_op(2'b00, 4'd3, 32'hDEADBEEF, '0, '0);
      ra0 = 4'd3; ra1 = 4'd3; dbg_sel = 4'd3;
      #1;
      check("alu_bypass_rd0", rd0, 32'hDEADBEEF);
      check("alu_bypass_rd1", rd1, 32'hDEADBEEF);
      check("alu_dbg_nobypass", dbg_data, 32'h0);
      next_cycle();
      in_valid = 1'b0;
      #1;
      check("alu_dbg_r3", dbg_data, 32'hDEADBEEF);
      check("alu_retired", {16'b0, retired}, 32'd1);

      // ALU write to r0 is discarded but retires
      drive_op(2'b00, 4'd0, 32'd7, '0, '0);
      ra0 = 4'd0; dbg_sel = 4'd0;
      #1;
      check("r0_rd0", rd0, 32'h0);
      next_cycle();
      in_valid = 1'b0;
      #1;
      check("r0_dbg", dbg_data, 32'h0);
      check("r0_retired", {16'b0, retired}, 32'd2);

      // Bubble: no write, no retire
      drive_op(2'b11, 4'd4, 32'h1234, '0, '0);
      next_cycle();
      in_valid = 1'b0; dbg_sel = 4'd4;
      #1;
      check("bubble_dbg", dbg_data, 32'h0);
      check("bubble_retired", {16'b0, retired}, 32'd2);

      // Load r5 from 0x12, ack in the third busy cycle
      drive_op(2'b01, 4'd5, '0, 10'h12, '0);
      next_cycle();
      in_valid = 1'b0;
      #1;
      check("ld_req_c1", {31'b0, mem_req}, 32'd1);
      check("ld_we", {31'b0, mem_we}, 32'd0);
      check("ld_addr", {22'b0, mem_addr}, 32'h12);
      check("ld_ready_c1", {31'b0, in_ready}, 32'd0);
      next_cycle();
      #1;
      check("ld_req_c2", {31'b0, mem_req}, 32'd1);
      check("ld_ready_c2", {31'b0, in_ready}, 32'd0);
      next_cycle();
      mem_ack = 1'b1; mem_rdata = 32'h55; ra1 = 4'd5; dbg_sel = 4'd5;
      #1;
      check("ld_req_c3", {31'b0, mem_req}, 32'd1);
      check("ld_bypass_rd1", rd1, 32'h55);
      next_cycle();
      mem_ack = 1'b0;
      #1;
      check("ld_req_done", {31'b0, mem_req}, 32'd0);
      check("ld_ready_done", {31'b0, in_ready}, 32'd1);
      check("ld_dbg_r5", dbg_data, 32'h55);
      check("ld_retired", {16'b0, retired}, 32'd3);

      // Stray ack while idle is ignored
      mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
      next_cycle();
      mem_ack = 1'b0;
      #1;
      check("idle_ack_retired", {16'b0, retired}, 32'd3);
      check("idle_ack_r5", dbg_data, 32'h55);

      // Store with no ack times out after 15 busy cycles
      next_cycle();
      run_store(10'h3FF, 32'hA5A5A5A5, 1'b0, req_cycles);
      check("to_req_cycles", req_cycles, 32'd15);
      check("to_err", {31'b0, err}, 32'd1);
      check("to_retired", {16'b0, retired}, 32'd3);
      check("to_ready", {31'b0, in_ready}, 32'd1);
      err_clr = 1'b1;
      next_cycle();
      err_clr = 1'b0;
      #1;
      check("err_clr", {31'b0, err}, 32'd0);

      // Timeout coinciding with err_clr leaves err set
      next_cycle();
      run_store(10'h3FF, 32'hA5A5A5A5, 1'b1, req_cycles);
      check("to2_req_cycles", req_cycles, 32'd15);
      check("to2_err_wins", {31'b0, err}, 32'd1);

      // Reset two cycles into a load aborts it; later ack is ignored
      next_cycle();
      drive_op(2'b01, 4'd6, '0, 10'h20, '0);
      next_cycle();
      in_valid = 1'b0;
      next_cycle();
      next_cycle();
      #1;
      check("rb_req_before", {31'b0, mem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rb_req_in_reset", {31'b0, mem_req}, 32'd0);
      check("rb_ready_in_reset", {31'b0, in_ready}, 32'd1);
      check("rb_err_in_reset", {31'b0, err}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      mem_ack = 1'b1; mem_rdata = 32'h99;
      next_cycle();
      mem_ack = 1'b0; dbg_sel = 4'd6;
      #1;
      check("rb_r6", dbg_data, 32'h0);
      check("rb_retired", {16'b0, retired}, 32'd0);
      check("rb_req_after", {31'b0, mem_req}, 32'd0);

      // Retired counter wrap: 65535 back-to-back ALU writes, then one more
      drive_op(2'b00, 4'd1, 32'h0000CAFE, '0, '0);
      dbg_sel = 4'd1;
      repeat (65535) @(posedge clk);
      #2;
      check("wrap_ffff", {16'b0, retired}, 32'h0000FFFF);
      check("wrap_r1", dbg_data, 32'h0000CAFE);
      next_cycle();
      in_valid = 1'b0;
      #1;
      check("wrap_zero", {16'b0, retired}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_writeback_unit.md
MEM_WRITEBACK_UNIT -- requirements
Module: mem_writeback_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits.
REQ-002 Parameter NREGS, default 16, register count; power of two, >=2; RW = log2(NREGS).
REQ-003 Parameter AW, default 10, data-memory address width.
REQ-004 Parameter TIMEOUT, default 15, maximum cycles to wait for mem_ack; range 1..255.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 Reset  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  upstream operation valid.
REQ-008 in_ready  out  1  unit can accept; equals (state==IDLE).
REQ-009 in_kind  in  2  00 ALU-write, 01 load, 10 store, 11 bubble.
REQ-010 in_rd  in  RW  destination register.
REQ-011 in_result  in  XLEN  ALU result for ALU-write.
REQ-012 in_addr  in  AW  memory address for load/store.
REQ-013 in_sdata  in  XLEN  store data.
REQ-014 mem_req / mem_we  out  1/1  memory request, write-enable qualifier.
REQ-015 mem_addr / mem_wdata  out  AW/XLEN  registered request address and data.
REQ-016 mem_ack  in  1  memory completes request this cycle.
REQ-017 mem_rdata  in  XLEN  load data, valid when mem_ack=1.
REQ-018 ra0, ra1  in  RW  register-file read addresses.
REQ-019 rd0, rd1  out  XLEN  combinational read data.
REQ-020 dbg_sel / dbg_data  in RW / out XLEN  debug read port, no bypass.
REQ-021 err  out  1  sticky timeout flag; err_clr  in  1  clears err.
REQ-022 retired  out  16  count of completed operations.

Function
REQ-023 States IDLE and BUSY only; accept = in_valid & in_ready.
REQ-024 ALU-write accepted in cycle N SHALL write in_result to in_rd at end of cycle N; state stays IDLE.
REQ-025 Bubble accepted SHALL cause no write, no memory request, no retired increment.
REQ-026 Load/store accepted in cycle N SHALL latch in_rd, in_addr, in_sdata, kind and enter BUSY at end of cycle N.
REQ-027 In BUSY, mem_req SHALL be 1, mem_we SHALL be 1 for store and 0 for load, mem_addr/mem_wdata stable from latched values.
REQ-028 mem_ack in BUSY: load writes mem_rdata to latched rd at that edge; store writes nothing; state returns to IDLE; mem_req low next cycle.
REQ-029 mem_ack while IDLE SHALL be ignored.
REQ-030 Timeout counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ack; BUSY cycle number TIMEOUT (1-based) without ack SHALL set err, return to IDLE, no register write, no retired increment.
REQ-031 err_clr SHALL clear err; timeout and err_clr in the same cycle SHALL leave err=1.
REQ-032 Register 0 SHALL read as 0 on all ports; writes to register 0 SHALL be discarded but count as retired.
REQ-033 rd0/rd1 SHALL bypass: if a write to register r>0 commits at the end of the current cycle, reads of r return that write's data in the same cycle.
REQ-034 retired SHALL increment by 1 on every ALU-write acceptance and every mem_ack in BUSY; wraps 0xFFFF->0x0000.
REQ-035 Back-to-back ALU-writes SHALL sustain one per cycle; load/store throughput is one per (latency+1) cycles minimum 2.

Reset
REQ-036 Reset low SHALL immediately force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, retired=0, timeout counter 0, all registers 0.
REQ-037 Reset asserted during BUSY SHALL abort the request with no register write; in_ready=1 after release.
REQ-038 Outputs SHALL have these values continuously while Reset is low.

Verification
REQ-039 ALU-write rd=3 result 0xDEADBEEF with ra0=3 same cycle -> rd0=0xDEADBEEF that cycle; next cycle dbg_sel=3 -> 0xDEADBEEF; retired=1.
REQ-040 Load rd=5 addr 0x12, mem_ack 3 cycles after mem_req rises, rdata 0x55 -> mem_req high exactly 3 cycles, in_ready=0 throughout, reg5=0x55, retired+1.
REQ-041 Store addr 0x3FF data 0xA5A5A5A5, no ack -> mem_req high TIMEOUT=15 cycles, mem_we=1, err=1, retired unchanged; err_clr -> err=0.
REQ-042 ALU-write rd=0 value 7 -> rd0(ra0=0)=0, dbg_data=0, retired increments.
REQ-043 Reset pulse 2 cycles after load enters BUSY, then mem_ack -> mem_req=0 during reset, target register stays 0, ack ignored.
REQ-044 Preload retired to 0xFFFF by 65535 ALU-writes, one more -> retired=0x0000.
